// File: rtl/hs_grant_responder.sv
// Responder side of the level request/grant handshake: grants after GNT_DLY cycles,
// counts xfer beats while granted, and pulses done with the beat count. Optional HS_TIMEOUT_EN.
module hs_grant_responder #(
  parameter int GNT_DLY  = 3,
  parameter int CW       = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          xfer,
  output logic          gnt,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] beats,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GRANT = 3'd2,
    DONE  = 3'd3
`ifdef HS_TIMEOUT_EN
    , ERR = 3'd4
`endif
  } state_t;

  localparam logic [CW-1:0] BEAT_MAX = {CW{1'b1}};

  if (GNT_DLY < 1 || GNT_DLY > 15 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_param
    $error("hs_grant_responder: parameter out of range");
  end

  state_t        state_q, state_d;
  logic [3:0]    dly_q, dly_d;
  logic [CW-1:0] beat_q, beat_d, beat_nxt;
  logic [CW-1:0] beats_q, beats_d;
  logic          gnt_q, gnt_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef HS_TIMEOUT_EN
  logic [7:0]    idle_q, idle_d;
`endif

  // Saturating count including the beat sampled on this edge.
  assign beat_nxt = (xfer && beat_q != BEAT_MAX) ? beat_q + 1'b1 : beat_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    beat_d  = beat_q;
    beats_d = beats_q;
    gnt_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef HS_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          busy_d  = 1'b1;
          dly_d   = 4'(GNT_DLY - 1);
          beat_d  = '0;
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (!req) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (dly_q == 4'd0) begin
          state_d = GRANT;
          gnt_d   = 1'b1;
`ifdef HS_TIMEOUT_EN
          idle_d  = '0;
`endif
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      GRANT: begin
        gnt_d  = 1'b1;
        busy_d = 1'b1;
        beat_d = beat_nxt;
        if (!req) begin
          state_d = DONE;
          gnt_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          beats_d = beat_nxt;
        end
`ifdef HS_TIMEOUT_EN
        // A request dropping on the timeout edge still completes normally.
        else if (xfer) begin
          idle_d = '0;
        end else if (idle_q + 8'd1 == 8'(HOLD_MAX)) begin
          state_d = ERR;
          gnt_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
`ifdef HS_TIMEOUT_EN
      ERR: begin
        err_d = 1'b1;
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dly_q   <= '0;
      beat_q  <= '0;
      beats_q <= '0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef HS_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      beat_q  <= beat_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef HS_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign beats = beats_q;
  assign err   = err_q;

endmodule

// File: tb/tb_hs_grant_responder.sv
// Directed bench for hs_grant_responder (GNT_DLY=3, CW=4, HOLD_MAX=8); HS_TIMEOUT_EN selects
// the timeout expectations.
module tb_hs_grant_responder;

  logic       clk, rst_n, req, xfer;
  logic       gnt, busy, done, err;
  logic [3:0] beats;
  int         checks = 0;
  int         errors = 0;

  hs_grant_responder #(.GNT_DLY(3), .CW(4), .HOLD_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .xfer(xfer),
    .gnt(gnt), .busy(busy), .done(done), .beats(beats), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; sample 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; xfer = 1'b0;
    #2;
    tick(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_beats", 32'(beats), 0);

    // Edge k: first edge with rst_n=1 samples req -> WAIT; grant at k+3.
    rst_n = 1'b1;
    tick(1);
    chk("k_busy", 32'(busy), 1);
    chk("k_gnt", 32'(gnt), 0);
    tick(2);
    chk("k2_gnt", 32'(gnt), 0);
    tick(1);
    chk("k3_gnt", 32'(gnt), 1);
    chk("k3_busy", 32'(busy), 1);

    // Normal transaction: 5 beats then idle, req falls with xfer=0.
    xfer = 1'b1;
    tick(5);
    xfer = 1'b0;
    tick(2);
    chk("norm_gnt_held", 32'(gnt), 1);
    req = 1'b0;
    tick(1);
    chk("norm_done", 32'(done), 1);
    chk("norm_beats", 32'(beats), 5);
    chk("norm_gnt_fall", 32'(gnt), 0);
    chk("norm_busy_fall", 32'(busy), 0);
    tick(1);
    chk("norm_done_pulse", 32'(done), 0);
    chk("norm_beats_held", 32'(beats), 5);
    tick(1);

    // Cancel during WAIT.
    req = 1'b1;
    tick(2);
    chk("cancel_busy", 32'(busy), 1);
    req = 1'b0;
    tick(1);
    chk("cancel_busy_drop", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("cancel_no_gnt", 32'(gnt), 0);
      chk("cancel_no_done", 32'(done), 0);
      tick(1);
    end

    // Saturation: 20 beats into a 4-bit counter.
    req = 1'b1;
    tick(4);
    chk("sat_gnt", 32'(gnt), 1);
    xfer = 1'b1;
    tick(20);
    xfer = 1'b0;
    req  = 1'b0;
    tick(1);
    chk("sat_done", 32'(done), 1);
    chk("sat_beats", 32'(beats), 15);
    tick(2);

    // Coincident: 3 beats, then xfer on the req-falling edge counts as the 4th.
    req = 1'b1;
    tick(4);
    chk("coin_gnt", 32'(gnt), 1);
    xfer = 1'b1;
    tick(3);
    req = 1'b0;
    tick(1);
    chk("coin_done", 32'(done), 1);
    chk("coin_beats", 32'(beats), 4);
    // Request raised during DONE is ignored until resampled in IDLE.
    req  = 1'b1;
    xfer = 1'b0;
    tick(1);
    chk("redo_idle_busy", 32'(busy), 0);
    chk("redo_idle_done", 32'(done), 0);
    tick(1);
    chk("redo_wait_busy", 32'(busy), 1);
    chk("redo_wait_gnt", 32'(gnt), 0);
    tick(2);
    chk("redo_pre_gnt", 32'(gnt), 0);
    tick(1);
    chk("redo_gnt", 32'(gnt), 1);

    // Held request with no beats: times out only when HS_TIMEOUT_EN is defined.
    tick(7);
    chk("hold7_gnt", 32'(gnt), 1);
    chk("hold7_err", 32'(err), 0);
    tick(1);
`ifdef HS_TIMEOUT_EN
    chk("to_gnt", 32'(gnt), 0);
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_done", 32'(done), 0);
    tick(3);
    chk("to_err_held", 32'(err), 1);
    req = 1'b0;
    tick(1);
    chk("to_err_clr", 32'(err), 0);
    chk("to_no_done", 32'(done), 0);
`else
    chk("nto_gnt8", 32'(gnt), 1);
    chk("nto_err", 32'(err), 0);
    tick(20);
    chk("nto_gnt28", 32'(gnt), 1);
    req = 1'b0;
    tick(1);
    chk("nto_done", 32'(done), 1);
    chk("nto_beats", 32'(beats), 0);
`endif
    tick(2);

    // Reset mid-transaction: grant drops with no done pulse.
    req = 1'b1;
    xfer = 1'b1;
    tick(4);
    chk("mid_gnt", 32'(gnt), 1);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_beats", 32'(beats), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_grant_responder.md
Name: hs_grant_responder

Overview:
- Responder end of the single-bit request/grant handshake driven by the team's Fizzim2-generated initiator FSMs.
- Accepts a level request and returns a registered grant after a programmable delay.
- While granted, counts transfer beats and reports completion with a one-cycle done pulse plus the beat count.
- Sits between an initiator FSM and a shared resource; all outputs are registered (state and transition outputs both flopped).

Parameters:
- GNT_DLY, 3, cycles from request acceptance to grant assertion; legal range 1..15.
- CW, 4, width of the beat counter and of the beats output.
- HOLD_MAX, 8, consecutive idle granted cycles before timeout; used only with the optional feature; range 1..255.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- req  input  1  level request from the initiator; held high for the whole transaction.
- xfer  input  1  beat strobe from the initiator; counted only while gnt=1.
- gnt  output  1  registered grant.
- busy  output  1  high in WAIT and GRANT.
- done  output  1  one-cycle pulse at transaction end.
- beats  output  CW  xfer count of the finished transaction; valid when done=1, held otherwise.
- err  output  1  timeout flag (optional feature).

Behaviour:
- Reset: rst_n=0 at a rising edge forces state IDLE and clears gnt, busy, done, beats, err and the internal counters. No asynchronous path exists.
- Reset mid-transaction: the block drops gnt on the same edge with no done pulse.
- States: IDLE, WAIT, GRANT, DONE, ERR (ERR exists only with the macro).
- IDLE:
  - Outputs: gnt=0, busy=0.
  - req=1 sampled at edge k → WAIT, busy=1, dly_cnt=GNT_DLY-1, beat_cnt cleared.
- WAIT:
  - req=0 → IDLE, busy=0, no done (cancelled request).
  - req=1 and dly_cnt=0 → GRANT, gnt=1.
  - Otherwise dly_cnt decrements.
  - gnt therefore rises at edge k+GNT_DLY.
- GRANT:
  - Each edge with xfer=1 increments beat_cnt, saturating at 2^CW-1.
  - req=0 → DONE: gnt=0, busy=0, done=1, beats=beat_cnt plus the current xfer.
  - An xfer coincident with req falling is counted.
- DONE:
  - Lasts exactly one cycle; done returns to 0, then → IDLE.
  - If req is already high in that cycle it is ignored; it is resampled in IDLE on the next edge.
- Minimum request-to-request spacing: one IDLE cycle after DONE.
- xfer outside GRANT is ignored.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- Defined:
  - An idle counter in GRANT clears on xfer=1 and increments otherwise.
  - On reaching HOLD_MAX → ERR: gnt=0, busy=0, err=1, no done pulse.
  - err stays high until req=0 is sampled, then → IDLE with err=0 on that edge.
  - req falling on the same edge the counter reaches HOLD_MAX takes the normal DONE path.
- Not defined: no idle counter, no ERR state, err tied to 0; HOLD_MAX is unused.

Test Plan:
- Reset hold: rst_n=0 for 2 edges with req=1 → gnt, busy, done, err all 0; req=1 sampled at the first rst_n=1 edge k → gnt=1 after edge k+3.
- Normal transaction: GNT_DLY=3, req high 10 cycles with 5 xfer beats while granted → done=1 for exactly one cycle, beats=5, gnt falls on the same edge.
- Cancel: req high 2 cycles then low during WAIT → gnt never asserts, no done, busy=0 after the next edge.
- Saturation: CW=4 with 20 xfer beats in GRANT → beats=15.
- Coincident events: xfer=1 on the edge req falls after 3 prior beats → beats=4. Also req re-raised during DONE → next WAIT entered one cycle after returning to IDLE.
- With HS_TIMEOUT_EN, HOLD_MAX=8: req held with no xfer → err=1 and gnt=0 after 8 granted cycles; after req drops, err=0 on the next edge. Without the macro, the same stimulus keeps gnt=1 indefinitely.
